bp_clint_ctrl: RTL
==================

BP_CLINT_CTRL -- requirements
Module: bp_clint_ctrl

Interface
REQ-001 SHALL have parameter addr_width_p, default 32: request address width in bits.
REQ-002 SHALL have parameter data_width_p, default 64: request/response data width and mtime/mtimecmp width.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port rtc_tick_i, input, 1: one-cycle real-time tick pulse; advances mtime.
REQ-006 SHALL have port req_v_i, input, 1: request valid.
REQ-007 SHALL have port req_ready_o, output, 1: request accepted when req_v_i & req_ready_o.
REQ-008 SHALL have port req_w_i, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_size_i, input, 1: 0 = 4-byte access, 1 = 8-byte access.
REQ-010 SHALL have port req_addr_i, input, addr_width_p: byte address.
REQ-011 SHALL have port req_data_i, input, data_width_p: write data; 4-byte writes use bits [31:0].
REQ-012 SHALL have port resp_v_o, output, 1: response valid.
REQ-013 SHALL have port resp_ready_i, input, 1: response consumed when resp_v_o & resp_ready_i.
REQ-014 SHALL have port resp_data_o, output, data_width_p: read data, zero-extended; 0 for writes and errors.
REQ-015 SHALL have port resp_err_o, output, 1: unmapped or misaligned access.
REQ-016 SHALL have port timer_irq_o, output, 1: machine timer interrupt.
REQ-017 SHALL have port software_irq_o, output, 1: machine software interrupt.

Function
REQ-018 SHALL implement FSM states READY and RESP; req_ready_o = (state == READY); resp_v_o = (state == RESP).
REQ-019 SHALL go READY->RESP on request accept, capturing resp_data_o/resp_err_o; RESP->READY on resp_ready_i; stay in RESP otherwise, with response outputs held stable.
REQ-020 SHALL allow at most one outstanding request; minimum latency is accept at cycle N, resp_v_o at N+1.
REQ-021 SHALL decode 8-byte-aligned word addresses: mipi 0x0200_0000; mtimecmp 0x0200_4000; mtime 0x0200_BFF8; every other address SHALL give resp_err_o = 1, no state change.
REQ-022 SHALL accept 4-byte access at word offset +0 (bits [31:0]) or +4 (bits [63:32]); 8-byte access SHALL require addr[2:0] = 0; 4-byte access SHALL require addr[1:0] = 0; a misaligned access SHALL give resp_err_o = 1, no state change.
REQ-023 SHALL treat mipi as 1 bit (bit 0); reads of mipi SHALL return 0 in all other bits; writes SHALL ignore other bits; the upper half of mipi SHALL read 0 and ignore writes.
REQ-024 SHALL increment mtime by 1 on each cycle with rtc_tick_i = 1, wrapping 2^64-1 -> 0.
REQ-025 SHALL make a write to mtime in the same cycle as a tick take the written value only (no increment); a partial write SHALL leave the other half at its pre-tick value.
REQ-026 SHALL update written registers in the accept cycle; the new value SHALL be visible to a request accepted the next cycle.
REQ-027 SHALL drive timer_irq_o = (mtime >= mtimecmp), unsigned, registered one cycle after the operands change.
REQ-028 SHALL drive software_irq_o = mipi bit 0, combinationally from the register.
REQ-029 SHALL return mtime read data sampled at accept, before that cycle's tick.

Reset
REQ-030 SHALL on reset_i = 1: state = READY; mtime = 0; mtimecmp = all-ones; mipi = 0; timer_irq_o = 0; resp_data_o = 0; resp_err_o = 0.
REQ-031 SHALL drop any in-flight response on reset asserted while in RESP; resp_v_o = 0 the following cycle.
REQ-032 SHALL ignore rtc_tick_i and requests during reset.

Verification
REQ-033 Reset, 10 ticks, 8-byte read 0x0200_BFF8 -> resp_data_o = 10, resp_err_o = 0, timer_irq_o = 0.
REQ-034 Write mtimecmp = 5 at 0x0200_4000, then 5 ticks -> timer_irq_o rises one cycle after mtime reaches 5; write mtimecmp = 100 -> timer_irq_o = 0 one cycle later.
REQ-035 4-byte write 0x1 to 0x0200_0000 -> software_irq_o = 1; write 0x0 -> 0; 4-byte read 0x0200_0004 -> 0.
REQ-036 Write mtime = 0xFFFF_FFFF_FFFF_FFFF, one tick -> read returns 0; 4-byte write 0x7 to 0x0200_BFFC coincident with a tick -> upper half = 0x7, lower half unincremented.
REQ-037 Read 0x0300_0000 -> resp_err_o = 1, data 0; 8-byte read 0x0200_4004 -> resp_err_o = 1; hold resp_ready_i = 0 for 3 cycles -> resp_v_o and data stable, req_ready_o = 0.
REQ-038 Assert reset_i while in RESP after a mtimecmp write -> resp_v_o = 0, mtimecmp = all-ones, mtime = 0.

Source files
------------

// File: rtl/bp_clint_ctrl.sv
// bp_clint_ctrl: core-local interruptor (CLINT) register block.
//
// Holds mtime, mtimecmp and the 1-bit mipi (software interrupt pending)
// register behind a single-outstanding request/response port.
//
// Ports
//   clk_i, reset_i       clock, synchronous active-high reset
//   rtc_tick_i           one-cycle tick; advances mtime
//   req_*                request channel (valid/ready, write, size, addr, data)
//   resp_*               response channel (valid/ready, data, error)
//   timer_irq_o          registered (mtime >= mtimecmp)
//   software_irq_o       mipi bit 0
//
// The 64-bit registers assume data_width_p >= 64.

`timescale 1ns/1ps

module bp_clint_ctrl #(
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned data_width_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    rtc_tick_i,
  input  logic                    req_v_i,
  output logic                    req_ready_o,
  input  logic                    req_w_i,
  input  logic                    req_size_i,
  input  logic [addr_width_p-1:0] req_addr_i,
  input  logic [data_width_p-1:0] req_data_i,
  output logic                    resp_v_o,
  input  logic                    resp_ready_i,
  output logic [data_width_p-1:0] resp_data_o,
  output logic                    resp_err_o,
  output logic                    timer_irq_o,
  output logic                    software_irq_o
);

  localparam logic StReady = 1'b0;
  localparam logic StResp  = 1'b1;

  localparam logic [addr_width_p-1:0] MipiAddr     = addr_width_p'(32'h0200_0000);
  localparam logic [addr_width_p-1:0] MtimecmpAddr = addr_width_p'(32'h0200_4000);
  localparam logic [addr_width_p-1:0] MtimeAddr    = addr_width_p'(32'h0200_BFF8);

  logic                    state_q, state_d;
  logic [63:0]             mtime_q, mtime_d;
  logic [63:0]             mtimecmp_q, mtimecmp_d;
  logic                    mipi_q, mipi_d;
  logic                    timer_irq_q;
  logic [data_width_p-1:0] resp_data_q, resp_data_d;
  logic                    resp_err_q, resp_err_d;

  logic [addr_width_p-1:0] word_addr;
  logic                    sel_mipi, sel_cmp, sel_mtime;
  logic                    misaligned, req_err, accept, wr_ok, hi;
  logic [63:0]             wdata, rd_word, rd_data;

  // Merge a 4- or 8-byte write into a 64-bit register image.
  function automatic logic [63:0] merge_word(input logic [63:0] old, input logic [63:0] wd,
                                             input logic size, input logic upper);
    if (size) begin
      merge_word = wd;
    end else if (upper) begin
      merge_word = {wd[31:0], old[31:0]};
    end else begin
      merge_word = {old[63:32], wd[31:0]};
    end
  endfunction

  always_comb begin
    word_addr  = {req_addr_i[addr_width_p-1:3], 3'b000};
    sel_mipi   = (word_addr == MipiAddr);
    sel_cmp    = (word_addr == MtimecmpAddr);
    sel_mtime  = (word_addr == MtimeAddr);
    hi         = req_addr_i[2];
    misaligned = req_size_i ? (req_addr_i[2:0] != 3'b000) : (req_addr_i[1:0] != 2'b00);
    req_err    = misaligned | ~(sel_mipi | sel_cmp | sel_mtime);
    accept     = req_v_i & (state_q == StReady);
    wr_ok      = accept & req_w_i & ~req_err;
    wdata      = req_data_i[63:0];

    // mtime is read pre-tick: mtime_q is this cycle's value before increment.
    if (sel_mipi) begin
      rd_word = {63'b0, mipi_q};
    end else if (sel_cmp) begin
      rd_word = mtimecmp_q;
    end else begin
      rd_word = mtime_q;
    end
    rd_data = req_size_i ? rd_word : {32'b0, (hi ? rd_word[63:32] : rd_word[31:0])};
  end

  always_comb begin
    state_d     = state_q;
    mtime_d     = rtc_tick_i ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    mipi_d      = mipi_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    // A write overrides the tick; the untouched half keeps its pre-tick value.
    if (wr_ok && sel_mtime) begin
      mtime_d = merge_word(mtime_q, wdata, req_size_i, hi);
    end
    if (wr_ok && sel_cmp) begin
      mtimecmp_d = merge_word(mtimecmp_q, wdata, req_size_i, hi);
    end
    // Upper half of mipi is read-as-zero, write-ignored.
    if (wr_ok && sel_mipi && (req_size_i || !hi)) begin
      mipi_d = wdata[0];
    end

    if (accept) begin
      resp_data_d = (req_w_i || req_err) ? '0 : data_width_p'(rd_data);
      resp_err_d  = req_err;
    end

    if (state_q == StReady) begin
      if (accept) state_d = StResp;
    end else begin
      if (resp_ready_i) state_d = StReady;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StReady;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      mipi_q      <= 1'b0;
      timer_irq_q <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      mipi_q      <= mipi_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready_o    = (state_q == StReady);
  assign resp_v_o       = (state_q == StResp);
  assign resp_data_o    = resp_data_q;
  assign resp_err_o     = resp_err_q;
  assign timer_irq_o    = timer_irq_q;
  assign software_irq_o = mipi_q;

endmodule
